mem_port_arbiter: RTL

Shares the single-ported unified memory between the pipeline's instruction-fetch stage and its MEM stage (lw/sw). Sequences one transaction at a time onto a variable-latency memory with a req/ready handshake. Raises a pipeline-wide stall while any requester waits. Flags memories that never respond with a watchdog timeout.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and
// the MEM stage, one transaction at a time, with a per-transaction watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_memread,
    input  logic              d_memwrite,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t            r_state,     w_nextState;
    logic              r_memReq,    w_nextMemReq;
    logic              r_memWe,     w_nextMemWe;
    logic [ADDR_W-1:0] r_memAddr,   w_nextMemAddr;
    logic [DATA_W-1:0] r_memWdata,  w_nextMemWdata;
    logic              r_ifAck,     w_nextIfAck;
    logic              r_dAck,      w_nextDAck;
    logic [DATA_W-1:0] r_ifRdata,   w_nextIfRdata;
    logic [DATA_W-1:0] r_dRdata,    w_nextDRdata;
    logic              r_err,       w_nextErr;
    logic [CNT_W-1:0]  r_waitCnt,   w_nextWaitCnt;

    logic              w_dPend;
    logic              w_iPend;
    logic [DATA_W-1:0] w_respData;

    // A requester still holding its request during its ack cycle is not re-served.
    assign w_dPend    = (d_memread | d_memwrite) & ~r_dAck;
    assign w_iPend    = if_req & ~r_ifAck;
    assign w_respData = mem_ready ? mem_rdata : '0;

    always_comb begin
        w_nextState    = r_state;
        w_nextMemReq   = r_memReq;
        w_nextMemWe    = r_memWe;
        w_nextMemAddr  = r_memAddr;
        w_nextMemWdata = r_memWdata;
        w_nextIfAck    = 1'b0;
        w_nextDAck     = 1'b0;
        w_nextIfRdata  = r_ifRdata;
        w_nextDRdata   = r_dRdata;
        w_nextErr      = r_err;
        w_nextWaitCnt  = r_waitCnt;

        case (r_state)
            IDLE: begin
                // Data wins ties: MEM holds the older instruction.
                if (w_dPend) begin
                    w_nextState    = DATA;
                    w_nextMemReq   = 1'b1;
                    w_nextMemWe    = d_memwrite;
                    w_nextMemAddr  = d_addr;
                    w_nextMemWdata = d_wdata;
                    w_nextWaitCnt  = '0;
                end else if (w_iPend) begin
                    w_nextState    = FETCH;
                    w_nextMemReq   = 1'b1;
                    w_nextMemWe    = 1'b0;
                    w_nextMemAddr  = if_addr;
                    w_nextWaitCnt  = '0;
                end
            end
            DATA, FETCH: begin
                w_nextWaitCnt = r_waitCnt + CNT_W'(1);
                if (mem_ready || (r_waitCnt == LAST_WAIT)) begin
                    w_nextState   = IDLE;
                    w_nextMemReq  = 1'b0;
                    w_nextWaitCnt = '0;
                    if (!mem_ready) begin
                        w_nextErr = 1'b1;
                    end
                    // Completed stores leave d_rdata alone; timeouts return zero.
                    if (r_state == DATA) begin
                        w_nextDAck = 1'b1;
                        if (!r_memWe || !mem_ready) begin
                            w_nextDRdata = w_respData;
                        end
                    end else begin
                        w_nextIfAck   = 1'b1;
                        w_nextIfRdata = w_respData;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_ifAck    <= 1'b0;
            r_dAck     <= 1'b0;
            r_ifRdata  <= '0;
            r_dRdata   <= '0;
            r_err      <= 1'b0;
            r_waitCnt  <= '0;
        end else begin
            r_state    <= w_nextState;
            r_memReq   <= w_nextMemReq;
            r_memWe    <= w_nextMemWe;
            r_memAddr  <= w_nextMemAddr;
            r_memWdata <= w_nextMemWdata;
            r_ifAck    <= w_nextIfAck;
            r_dAck     <= w_nextDAck;
            r_ifRdata  <= w_nextIfRdata;
            r_dRdata   <= w_nextDRdata;
            r_err      <= w_nextErr;
            r_waitCnt  <= w_nextWaitCnt;
        end
    end

    assign stall     = w_dPend | w_iPend;
    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign if_ack    = r_ifAck;
    assign d_ack     = r_dAck;
    assign if_rdata  = r_ifRdata;
    assign d_rdata   = r_dRdata;
    assign err       = r_err;

endmodule
